// File: rtl/gray_counter.sv
// Up/down Gray-code counter with binary mirror, load, wrap/saturate and overflow pulse.
// One-cycle latency for g/bin/ovf; at_term is combinational from bin and up.
module gray_counter #(
  parameter int W    = 3,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] g,
  output logic [W-1:0] bin,
  output logic         ovf,
  output logic         at_term
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] step_val;
  logic [W-1:0] next_bin;
  logic         next_ovf;

  // at_term depends only on bin and up, never on ovf, so no loop exists.
  assign at_term  = up ? (bin == MAX) : (bin == '0);
  assign step_val = up ? (bin + ONE) : (bin - ONE);

  always_comb begin
    next_bin = bin;
    next_ovf = 1'b0;
    if (load) begin
      next_bin = load_val;
    end else if (en) begin
      if (at_term) begin
        next_ovf = 1'b1;
        next_bin = WRAP ? step_val : bin;
      end else begin
        next_bin = step_val;
      end
    end
  end

  // g is derived from next_bin so both registers always update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin <= '0;
      g   <= '0;
      ovf <= 1'b0;
    end else begin
      bin <= next_bin;
      g   <= next_bin ^ (next_bin >> 1);
      ovf <= next_ovf;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed checks on W=3 wrap/saturate instances plus a modelled random soak at W=4 and W=8.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // shared stimulus for the two W=3 instances
  logic       rst_n = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] a_g, a_bin, b_g, b_bin;
  logic       a_ovf, a_at, b_ovf, b_at;

  gray_counter #(.W(3), .WRAP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .g(a_g), .bin(a_bin), .ovf(a_ovf), .at_term(a_at));

  gray_counter #(.W(3), .WRAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .g(b_g), .bin(b_bin), .ovf(b_ovf), .at_term(b_at));

  // soak instances
  logic       c_rst_n = 1'b0, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0;
  logic [3:0] c_lv = '0, c_g, c_bin;
  logic       c_ovf, c_at;
  logic       d_rst_n = 1'b0, d_en = 1'b0, d_up = 1'b0, d_load = 1'b0;
  logic [7:0] d_lv = '0, d_g, d_bin;
  logic       d_ovf, d_at;

  gray_counter #(.W(4), .WRAP(1'b0)) u_c (
    .clk(clk), .rst_n(c_rst_n), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv),
    .g(c_g), .bin(c_bin), .ovf(c_ovf), .at_term(c_at));

  gray_counter #(.W(8), .WRAP(1'b1)) u_d (
    .clk(clk), .rst_n(d_rst_n), .en(d_en), .up(d_up), .load(d_load), .load_val(d_lv),
    .g(d_g), .bin(d_bin), .ovf(d_ovf), .at_term(d_at));

  logic [2:0] gseq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gray2bin(input logic [7:0] gv);
    logic [7:0] r;
    r[7] = gv[7];
    for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
    return r;
  endfunction

  // reference model: returns {ovf, bin}
  function automatic logic [8:0] model(input logic [7:0] b, input int w, input bit wrap,
                                       input logic rs, input logic ld, input logic e,
                                       input logic u, input logic [7:0] lv);
    logic [7:0] mx;
    logic [7:0] nb;
    logic       term;
    mx = 8'((1 << w) - 1);
    if (!rs) return 9'd0;
    if (ld) return {1'b0, lv & mx};
    if (!e) return {1'b0, b};
    term = u ? (b == mx) : (b == 8'd0);
    nb = (u ? b + 8'd1 : b - 8'd1) & mx;
    if (term) return {1'b1, wrap ? nb : b};
    return {1'b0, nb};
  endfunction

  initial begin
    logic [8:0] mc, md;
    logic [7:0] pc_g, pd_g, pc_b;
    logic       c_step, d_step;

    // reset held for two clocks
    step(); step();
    check("reset_g", a_g, 0);
    check("reset_bin", a_bin, 0);
    check("reset_ovf", a_ovf, 0);

    // up count with wrap
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("up_g_%0d", i), a_g, gseq[i]);
      check($sformatf("up_bin_%0d", i), a_bin, (i + 1) % 8);
      check($sformatf("up_ovf_%0d", i), a_ovf, (i == 7) ? 1 : 0);
      check($sformatf("up_gray2bin_%0d", i), gray2bin({5'b0, a_g}), a_bin);
    end
    check("sat_after8_bin", b_bin, 7);
    check("sat_after8_ovf", b_ovf, 1);

    en = 1'b0;
    step();
    check("hold_bin", a_bin, 0);
    check("hold_ovf", a_ovf, 0);
    up = 1'b0;
    #1 check("at_term_down_zero", a_at, 1);

    // down wrap from reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    en = 1'b1; up = 1'b0;
    step();
    check("down_wrap_bin", a_bin, 7);
    check("down_wrap_g", a_g, 3'b100);
    check("down_wrap_ovf", a_ovf, 1);
    step();
    check("down2_bin", a_bin, 6);
    check("down2_g", a_g, 3'b101);
    check("down2_ovf", a_ovf, 0);

    // load beats count
    load = 1'b1; load_val = 3'd5; up = 1'b1;
    step();
    check("load_bin", a_bin, 5);
    check("load_g", a_g, 3'b111);
    check("load_ovf", a_ovf, 0);
    load = 1'b0;
    step();
    check("post_load_bin", a_bin, 6);
    check("post_load_g", a_g, 3'b101);

    // saturate mode
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sat_bin_%0d", i), b_bin, 7);
      check($sformatf("sat_g_%0d", i), b_g, 3'b100);
      check($sformatf("sat_ovf_%0d", i), b_ovf, 1);
      check($sformatf("sat_term_%0d", i), b_at, 1);
    end
    up = 1'b0;
    step();
    check("sat_down_bin", b_bin, 6);
    check("sat_down_ovf", b_ovf, 0);

    // reset mid-count overrides load and en
    rst_n = 1'b0; step(); rst_n = 1'b1;
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_pre_bin", a_bin, 4);
    check("mid_pre_g", a_g, 3'b110);
    rst_n = 1'b0; load = 1'b1; load_val = 3'd3;
    step();
    check("mid_rst_bin", a_bin, 0);
    check("mid_rst_g", a_g, 0);
    check("mid_rst_ovf", a_ovf, 0);
    rst_n = 1'b1; load = 1'b0;
    step();
    check("mid_resume_bin", a_bin, 1);
    check("mid_resume_g", a_g, 3'b001);

    // random soak against the model
    step();
    mc = 9'd0; md = 9'd0;
    for (int n = 0; n < 2000; n++) begin
      c_rst_n = ($urandom_range(63) != 0); c_load = ($urandom_range(15) == 0);
      c_en = ($urandom_range(3) != 0);     c_up = $urandom_range(1);
      c_lv = 4'($urandom);
      d_rst_n = ($urandom_range(63) != 0); d_load = ($urandom_range(15) == 0);
      d_en = ($urandom_range(3) != 0);     d_up = $urandom_range(1);
      d_lv = 8'($urandom);
      #1;
      check("soak_c_term", c_at, c_up ? (mc[7:0] == 8'd15) : (mc[7:0] == 8'd0));
      check("soak_d_term", d_at, d_up ? (md[7:0] == 8'd255) : (md[7:0] == 8'd0));
      pc_g = {4'b0, c_g}; pd_g = d_g; pc_b = mc[7:0];
      c_step = c_rst_n && !c_load && c_en;
      d_step = d_rst_n && !d_load && d_en;
      mc = model(mc[7:0], 4, 1'b0, c_rst_n, c_load, c_en, c_up, {4'b0, c_lv});
      md = model(md[7:0], 8, 1'b1, d_rst_n, d_load, d_en, d_up, d_lv);
      step();
      check("soak_c_bin", c_bin, mc[7:0]);
      check("soak_c_ovf", c_ovf, mc[8]);
      check("soak_c_g", c_g, mc[3:0] ^ (mc[3:0] >> 1));
      check("soak_d_bin", d_bin, md[7:0]);
      check("soak_d_ovf", d_ovf, md[8]);
      check("soak_d_g", d_g, md[7:0] ^ (md[7:0] >> 1));
      if (c_step && pc_b != mc[7:0])
        check("soak_c_onebit", $countones(pc_g ^ {4'b0, c_g}), 1);
      if (d_step)
        check("soak_d_onebit", $countones(pd_g ^ d_g), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
